// File: rtl/pipe_ctrl_if.sv
// Pipeline control bus: stall/flush/redirect requests from the datapath in,
// per-stage load/bubble controls and sequencing state out.
interface pipe_ctrl_if #(
    parameter int unsigned STAGES = 5,
    parameter int unsigned PC_W   = 32,
    parameter int unsigned CNT_W  = 32
);
    logic [STAGES-1:0]      stall_req;
    logic [STAGES-1:0]      flush_req;
    logic [PC_W-1:0]        flush_pc;
    logic                   redirect;
    logic [PC_W-1:0]        redirect_pc;
    logic [PC_W-1:0]        pcF;
    logic [STAGES-1:0]      en_o;
    logic [STAGES-1:0]      bubble_o;
    logic [STAGES-1:0]      valid_o;
    logic [STAGES*PC_W-1:0] pc_o;
    logic [PC_W-1:0]        pcW;
    logic [CNT_W-1:0]       stall_cnt;

    modport master (
        output stall_req, flush_req, flush_pc, redirect, redirect_pc,
        input  pcF, en_o, bubble_o, valid_o, pc_o, pcW, stall_cnt
    );

    modport slave (
        input  stall_req, flush_req, flush_pc, redirect, redirect_pc,
        output pcF, en_o, bubble_o, valid_o, pc_o, pcW, stall_cnt
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: owns fetch PC, per-stage valid/PC, and
// turns stall/flush requests into per-stage load-enable and bubble controls.
// Redirects that arrive while fetch is held are parked in a pending slot.
module pipe_ctrl #(
    parameter int unsigned     STAGES   = 5,
    parameter int unsigned     PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = 32'hbfc00000,
    parameter int unsigned     CNT_W    = 32
) (
    input  logic       clk,
    input  logic       rst,
    pipe_ctrl_if.slave bus
);
    typedef enum logic {
        PEND_NONE,
        PEND_HELD
    } pend_t;

    pend_t             pend_q, pend_n;
    logic [PC_W-1:0]   pend_pc_q, pend_pc_n;
    logic [PC_W-1:0]   pc_q [STAGES];
    logic [PC_W-1:0]   pc_n [STAGES];
    logic [STAGES-1:0] valid_q, valid_n;
    logic [CNT_W-1:0]  cnt_q, cnt_n;
    logic [STAGES-1:0] en, bubble;

    logic              has_stall, has_flush;
    int unsigned       s, k;
    logic              flush_over, flush_under, hold, stall_only;

    // State registers; pc_q[0] is the fetch PC
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                pc_q[i] <= '0;
            end
            pc_q[0]   <= RESET_PC;
            valid_q   <= STAGES'(1);
            pend_q    <= PEND_NONE;
            pend_pc_q <= '0;
            cnt_q     <= '0;
        end else begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                pc_q[i] <= pc_n[i];
            end
            valid_q   <= valid_n;
            pend_q    <= pend_n;
            pend_pc_q <= pend_pc_n;
            cnt_q     <= cnt_n;
        end
    end

    // Request decode, per-stage controls and next-state computation
    always_comb begin
        has_stall = 1'b0;
        s         = 0;
        has_flush = 1'b0;
        k         = 0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            if (bus.stall_req[i]) begin
                has_stall = 1'b1;
                s         = i;
            end
        end
        for (int unsigned i = 1; i < STAGES; i++) begin
            if (bus.flush_req[i]) begin
                has_flush = 1'b1;
                k         = i;
            end
        end

        // A flush at or beyond the stall point overrides the stall; a stall
        // further down still freezes the upper pipe with in-place squash.
        flush_over  = has_flush && (!has_stall || (s <= k));
        flush_under = has_flush && has_stall && (s > k);
        hold        = has_stall && !flush_over;
        stall_only  = has_stall && !has_flush;

        en      = '1;
        bubble  = '0;
        valid_n = valid_q;
        pc_n    = pc_q;
        for (int unsigned i = 0; i < STAGES; i++) begin
            if (hold) begin
                if (i <= s) begin
                    en[i] = 1'b0;
                end else if (i == s + 1) begin
                    bubble[i] = 1'b1;
                end
            end else if (flush_over) begin
                if ((i >= 1) && (i <= k + 1)) begin
                    bubble[i] = 1'b1;
                end
            end
        end

        for (int unsigned i = 1; i < STAGES; i++) begin
            if (!en[i]) begin
                if (flush_under && (i <= k)) begin
                    valid_n[i] = 1'b0;
                end
            end else if (bubble[i]) begin
                valid_n[i] = 1'b0;
                pc_n[i]    = '0;
            end else begin
                valid_n[i] = valid_q[i-1];
                pc_n[i]    = pc_q[i-1];
            end
        end
        valid_n[0] = 1'b1;

        pend_n    = pend_q;
        pend_pc_n = pend_pc_q;
        if (has_flush) begin
            pc_n[0] = bus.flush_pc;
            pend_n  = PEND_NONE;
        end else if (has_stall) begin
            if (bus.redirect && valid_q[1]) begin
                pend_n    = PEND_HELD;
                pend_pc_n = bus.redirect_pc;
            end
        end else if (bus.redirect && valid_q[1]) begin
            pc_n[0] = bus.redirect_pc;
            pend_n  = PEND_NONE;
        end else if (pend_q == PEND_HELD) begin
            pc_n[0] = pend_pc_q;
            pend_n  = PEND_NONE;
        end else begin
            pc_n[0] = pc_q[0] + PC_W'(4);
        end

        cnt_n = cnt_q;
        if (stall_only && (cnt_q != '1)) begin
            cnt_n = cnt_q + CNT_W'(1);
        end
    end

    // Flatten per-stage PCs onto the debug bus
    for (genvar g = 0; g < STAGES; g++) begin : g_pc
        assign bus.pc_o[g*PC_W +: PC_W] = pc_q[g];
    end

    assign bus.pcF       = pc_q[0];
    assign bus.pcW       = pc_q[STAGES-1];
    assign bus.valid_o   = valid_q;
    assign bus.en_o      = en;
    assign bus.bubble_o  = bubble;
    assign bus.stall_cnt = cnt_q;
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Parametrised pipeline sequencing controller for the in-order MIPS core. It generalises the fixed five-stage stall/flush wiring to STAGES stages. It owns the fetch PC, the per-stage valid bits and the per-stage PCs used by the debug writeback port. It turns per-stage stall/flush requests into per-stage load-enable and bubble-insert controls for the datapath pipeline registers. Branch redirects that arrive while fetch is held are buffered rather than lost.

Parameters:
STAGES, 5, number of stages; index 0 = F (PC register), STAGES-1 = W
PC_W, 32, PC width
RESET_PC, 32'hbfc00000, fetch PC after reset
CNT_W, 32, stall-cycle counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
stall_req  in  STAGES  bit i: stage i cannot advance this cycle
flush_req  in  STAGES  bit k: exception/flush raised by stage k (bit 0 ignored)
flush_pc  in  PC_W  fetch target on flush
redirect  in  1  branch/jump resolved taken in D (stage 1)
redirect_pc  in  PC_W  branch/jump target
pcF  out  PC_W  current fetch PC
en_o  out  STAGES  stage i register loads this edge
bubble_o  out  STAGES  stage i register loads a bubble this edge
valid_o  out  STAGES  registered valid per stage
pc_o  out  STAGES*PC_W  registered PC per stage, stage i at [i*PC_W +: PC_W]
pcW  out  PC_W  = PC of stage STAGES-1
stall_cnt  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Reset (async): pcF=RESET_PC; valid_o=1 at bit 0, 0 elsewhere; pc_o stages 1.. = 0; pending cleared; stall_cnt=0.
- s = highest i with stall_req[i]; none -> no stall.
- k = highest i>=1 with flush_req[i]; none -> no flush.
- No stall, no flush: every stage i>=1 loads valid/pc of stage i-1; en_o all 1; bubble_o all 0.
- Stall at s, no flush: stages 0..s hold (en_o=0). Stage s+1 (if < STAGES) loads a bubble (en_o=1, bubble_o=1, valid=0, pc=0). Stages > s+1 advance normally.
- Flush at k, no stall or s<=k: stalls are ignored. Stages 1..min(k+1,STAGES-1) load bubbles. Stages > k+1 advance. pcF<=flush_pc. Pending redirect cleared. valid[0] stays 1.
- Flush at k with s>k: stages 0..s hold except that valid of stages 1..k is cleared in place and pcF<=flush_pc. Stage s+1 gets a bubble. Pending is cleared.
- en_o/bubble_o are combinational from the current-cycle requests. valid_o/pc_o/pcF update on the clock edge.
- Next pcF, in priority order:
  1. flush -> flush_pc
  2. stage 0 held -> hold; if redirect && valid_o[1], latch redirect_pc into pending (overwrite any older pending)
  3. redirect && valid_o[1] -> redirect_pc; clear pending
  4. pending -> pending_pc; clear pending
  5. otherwise pcF+4, wrapping modulo 2^PC_W
- Delay-slot semantics: a redirect never squashes stages 0 or 1.
- stall_cnt: +1 on each cycle with a stall and no flush; saturates at all-ones.
- Reset mid-operation returns to the reset state immediately, regardless of pending or held stages.

Test Plan:
- Release reset, no requests, 6 cycles -> pcF = bfc00000, 04, 08, ...; valid_o fills to 5'b11111 after 4 edges; pcW=bfc00000 at cycle 4.
- stall_req=5'b00100 for 2 cycles -> stages 0..2 held; valid_o[3]=0 for 2 cycles; stages 3..4 drain; stall_cnt=2.
- redirect=1, redirect_pc=0x80001000 with no stall -> next pcF=0x80001000; stage-1 delay slot stays valid.
- stall_req=5'b00001 with redirect to 0x2000 in the same cycle, then released -> pcF holds for one cycle, then 0x2000; pcF never takes pc+4 in between.
- flush_req[3]=1, flush_pc=0xbfc00380, stall_req[1]=1 -> stall ignored; valid_o[1..4] = 0,0,0, then the old stage-3 contents are dropped; pcF=0xbfc00380; pending cleared.
- Force stall_cnt to all-ones minus 1 (CNT_W=4), stall 3 cycles -> counter stays at 4'hf. Assert rst mid-stall -> all outputs at reset values within the same cycle.
